reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 167 ++++++++++++++++
 tb/tb_reservation_station.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station: holds renamed instructions until both operands arrive,
// then dispatches the lowest-index ready entry to the ALU operand registers.
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [5:0]       issue_op,
  input  logic [ROB_W-1:0] issue_rd_rename,
  input  logic [31:0]      issue_pc,
  input  logic [31:0]      issue_imm,
  input  logic             issue_rs1_busy,
  input  logic             issue_rs2_busy,
  input  logic [ROB_W-1:0] issue_rs1_rename,
  input  logic [ROB_W-1:0] issue_rs2_rename,
  input  logic [31:0]      issue_rs1_value,
  input  logic [31:0]      issue_rs2_value,
  input  logic             alu_broadcast,
  input  logic [ROB_W-1:0] alu_rd_rename,
  input  logic [31:0]      alu_result,
  input  logic             lsb_broadcast,
  input  logic [ROB_W-1:0] lsb_rd_rename,
  input  logic [31:0]      lsb_result,
  input  logic             rollback,
  output logic             rs_full,
  output logic             alu_enable,
  output logic [5:0]       out_op,
  output logic [ROB_W-1:0] out_rd_rename,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic [31:0]      out_rs1_value,
  output logic [31:0]      out_rs2_value
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] valid, qj_busy, qk_busy;
  logic [5:0]         op [RS_SIZE];
  logic [ROB_W-1:0]   rd [RS_SIZE];
  logic [ROB_W-1:0]   qj [RS_SIZE];
  logic [ROB_W-1:0]   qk [RS_SIZE];
  logic [31:0]        pc [RS_SIZE];
  logic [31:0]        imm [RS_SIZE];
  logic [31:0]        vj [RS_SIZE];
  logic [31:0]        vk [RS_SIZE];

  logic             disp_found;
  logic [IDX_W-1:0] disp_idx, free_idx;

  assign rs_full = &valid;

  function automatic logic alu_hit(input logic [ROB_W-1:0] tag);
    return alu_broadcast && (alu_rd_rename == tag);
  endfunction

  function automatic logic lsb_hit(input logic [ROB_W-1:0] tag);
    return lsb_broadcast && (lsb_rd_rename == tag);
  endfunction

  // Scanning downward lets the lowest matching index overwrite earlier picks.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (valid[i] && !qj_busy[i] && !qk_busy[i]) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid         <= '0;
      qj_busy       <= '0;
      qk_busy       <= '0;
      alu_enable    <= 1'b0;
      out_op        <= '0;
      out_rd_rename <= '0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_rs1_value <= '0;
      out_rs2_value <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op[i]  <= '0;
        rd[i]  <= '0;
        qj[i]  <= '0;
        qk[i]  <= '0;
        pc[i]  <= '0;
        imm[i] <= '0;
        vj[i]  <= '0;
        vk[i]  <= '0;
      end
    end else if (rdy) begin
      if (rollback) begin
        valid      <= '0;
        alu_enable <= 1'b0;
      end else begin
        alu_enable <= disp_found;
        if (disp_found) begin
          out_op          <= op[disp_idx];
          out_rd_rename   <= rd[disp_idx];
          out_pc          <= pc[disp_idx];
          out_imm         <= imm[disp_idx];
          out_rs1_value   <= vj[disp_idx];
          out_rs2_value   <= vk[disp_idx];
          valid[disp_idx] <= 1'b0;
        end
        // Wakeup: ALU result is checked first so it wins a same-tag collision.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (valid[i] && qj_busy[i]) begin
            if (alu_hit(qj[i])) begin
              vj[i] <= alu_result;
              qj_busy[i] <= 1'b0;
            end else if (lsb_hit(qj[i])) begin
              vj[i] <= lsb_result;
              qj_busy[i] <= 1'b0;
            end
          end
          if (valid[i] && qk_busy[i]) begin
            if (alu_hit(qk[i])) begin
              vk[i] <= alu_result;
              qk_busy[i] <= 1'b0;
            end else if (lsb_hit(qk[i])) begin
              vk[i] <= lsb_result;
              qk_busy[i] <= 1'b0;
            end
          end
        end
        // The issue slot is always invalid, so it never collides with wakeup or dispatch.
        if (issue_valid && !rs_full) begin
          valid[free_idx] <= 1'b1;
          op[free_idx]    <= issue_op;
          rd[free_idx]    <= issue_rd_rename;
          pc[free_idx]    <= issue_pc;
          imm[free_idx]   <= issue_imm;
          qj[free_idx]    <= issue_rs1_rename;
          qk[free_idx]    <= issue_rs2_rename;
          if (issue_rs1_busy && alu_hit(issue_rs1_rename)) begin
            vj[free_idx] <= alu_result;
            qj_busy[free_idx] <= 1'b0;
          end else if (issue_rs1_busy && lsb_hit(issue_rs1_rename)) begin
            vj[free_idx] <= lsb_result;
            qj_busy[free_idx] <= 1'b0;
          end else begin
            vj[free_idx] <= issue_rs1_value;
            qj_busy[free_idx] <= issue_rs1_busy;
          end
          if (issue_rs2_busy && alu_hit(issue_rs2_rename)) begin
            vk[free_idx] <= alu_result;
            qk_busy[free_idx] <= 1'b0;
          end else if (issue_rs2_busy && lsb_hit(issue_rs2_rename)) begin
            vk[free_idx] <= lsb_result;
            qk_busy[free_idx] <= 1'b0;
          end else begin
            vk[free_idx] <= issue_rs2_value;
            qk_busy[free_idx] <= issue_rs2_busy;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios then random traffic, all
// compared each cycle against a list-of-instructions reference model.
module tb_reservation_station;
  logic        clk = 1'b0;
  logic        rst, rdy, issue_valid, issue_rs1_busy, issue_rs2_busy;
  logic [5:0]  issue_op;
  logic [3:0]  issue_rd_rename, issue_rs1_rename, issue_rs2_rename;
  logic [31:0] issue_pc, issue_imm, issue_rs1_value, issue_rs2_value;
  logic        alu_broadcast, lsb_broadcast, rollback;
  logic [3:0]  alu_rd_rename, lsb_rd_rename;
  logic [31:0] alu_result, lsb_result;
  logic        rs_full, alu_enable;
  logic [5:0]  out_op;
  logic [3:0]  out_rd_rename;
  logic [31:0] out_pc, out_imm, out_rs1_value, out_rs2_value;

  always #5 clk = ~clk;

  reservation_station #(.RS_SIZE(8), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_rd_rename(issue_rd_rename), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_rs1_busy(issue_rs1_busy), .issue_rs2_busy(issue_rs2_busy),
    .issue_rs1_rename(issue_rs1_rename), .issue_rs2_rename(issue_rs2_rename),
    .issue_rs1_value(issue_rs1_value), .issue_rs2_value(issue_rs2_value),
    .alu_broadcast(alu_broadcast), .alu_rd_rename(alu_rd_rename), .alu_result(alu_result),
    .lsb_broadcast(lsb_broadcast), .lsb_rd_rename(lsb_rd_rename), .lsb_result(lsb_result),
    .rollback(rollback), .rs_full(rs_full), .alu_enable(alu_enable), .out_op(out_op),
    .out_rd_rename(out_rd_rename), .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value)
  );

  typedef struct {
    bit          used;
    logic [5:0]  op;
    logic [3:0]  rd, tj, tk;
    logic [31:0] pc, imm, vj, vk;
    bit          wj, wk;
  } slot_t;

  slot_t       slots[8];
  bit          exp_en;
  logic [5:0]  exp_op;
  logic [3:0]  exp_rd;
  logic [31:0] exp_pc, exp_imm, exp_v1, exp_v2;
  int compared = 0;
  int mismatched = 0;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    foreach (slots[i]) slots[i].used = 0;
    exp_en = 0; exp_op = '0; exp_rd = '0;
    exp_pc = '0; exp_imm = '0; exp_v1 = '0; exp_v2 = '0;
  endtask

  // A waiting operand picks up a broadcast carrying its tag; ALU beats LSB.
  function automatic void snoop(inout bit waiting, input logic [3:0] tag, inout logic [31:0] v);
    if (!waiting) return;
    if (alu_broadcast && alu_rd_rename == tag) begin
      v = alu_result; waiting = 0;
    end else if (lsb_broadcast && lsb_rd_rename == tag) begin
      v = lsb_result; waiting = 0;
    end
  endfunction

  task automatic modelStep();
    int pick, hole, occupied;
    if (!rdy) return;
    if (rollback) begin
      foreach (slots[i]) slots[i].used = 0;
      exp_en = 0;
      return;
    end
    pick = -1; hole = -1; occupied = 0;
    foreach (slots[i]) begin
      if (slots[i].used) occupied++;
      if (pick < 0 && slots[i].used && !slots[i].wj && !slots[i].wk) pick = i;
      if (hole < 0 && !slots[i].used) hole = i;
    end
    exp_en = (pick >= 0);
    if (pick >= 0) begin
      exp_op = slots[pick].op; exp_rd = slots[pick].rd; exp_pc = slots[pick].pc;
      exp_imm = slots[pick].imm; exp_v1 = slots[pick].vj; exp_v2 = slots[pick].vk;
      slots[pick].used = 0;
    end
    foreach (slots[i]) if (slots[i].used) begin
      snoop(slots[i].wj, slots[i].tj, slots[i].vj);
      snoop(slots[i].wk, slots[i].tk, slots[i].vk);
    end
    if (issue_valid && occupied < 8) begin
      slots[hole] = '{1, issue_op, issue_rd_rename, issue_rs1_rename, issue_rs2_rename,
                      issue_pc, issue_imm, issue_rs1_value, issue_rs2_value,
                      issue_rs1_busy, issue_rs2_busy};
      snoop(slots[hole].wj, slots[hole].tj, slots[hole].vj);
      snoop(slots[hole].wk, slots[hole].tk, slots[hole].vk);
    end
  endtask

  task automatic checkOutput();
    int occupied = 0;
    foreach (slots[i]) if (slots[i].used) occupied++;
    checkValue("rs_full", 64'(rs_full), 64'(occupied == 8));
    checkValue("alu_enable", 64'(alu_enable), 64'(exp_en));
    checkValue("out_op", 64'(out_op), 64'(exp_op));
    checkValue("out_rd_rename", 64'(out_rd_rename), 64'(exp_rd));
    checkValue("out_pc", 64'(out_pc), 64'(exp_pc));
    checkValue("out_imm", 64'(out_imm), 64'(exp_imm));
    checkValue("out_rs1_value", 64'(out_rs1_value), 64'(exp_v1));
    checkValue("out_rs2_value", 64'(out_rs2_value), 64'(exp_v2));
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idleInputs();
    rdy = 1; issue_valid = 0; rollback = 0; alu_broadcast = 0; lsb_broadcast = 0;
  endtask

  task automatic setIssue(input logic [5:0] op, input logic [3:0] rd, input logic [31:0] imm,
                          input bit b1, input logic [3:0] t1, input logic [31:0] v1,
                          input bit b2, input logic [3:0] t2, input logic [31:0] v2);
    issue_valid = 1; issue_op = op; issue_rd_rename = rd; issue_imm = imm;
    issue_pc = $urandom; issue_rs1_busy = b1; issue_rs1_rename = t1; issue_rs1_value = v1;
    issue_rs2_busy = b2; issue_rs2_rename = t2; issue_rs2_value = v2;
  endtask

  task automatic randomInputs();
    rdy = ($urandom_range(0, 9) != 0);
    rollback = ($urandom_range(0, 49) == 0);
    issue_valid = $urandom_range(0, 1);
    issue_op = $urandom; issue_rd_rename = $urandom; issue_pc = $urandom; issue_imm = $urandom;
    issue_rs1_busy = $urandom_range(0, 1); issue_rs2_busy = $urandom_range(0, 1);
    issue_rs1_rename = $urandom; issue_rs2_rename = $urandom;
    issue_rs1_value = $urandom; issue_rs2_value = $urandom;
    alu_broadcast = $urandom_range(0, 1); alu_rd_rename = $urandom; alu_result = $urandom;
    lsb_broadcast = $urandom_range(0, 1); lsb_rd_rename = $urandom; lsb_result = $urandom;
  endtask

  initial begin
    rst = 1; idleInputs();
    issue_op = '0; issue_rd_rename = '0; issue_pc = '0; issue_imm = '0;
    issue_rs1_busy = 0; issue_rs2_busy = 0; issue_rs1_rename = '0; issue_rs2_rename = '0;
    issue_rs1_value = '0; issue_rs2_value = '0;
    alu_rd_rename = '0; alu_result = '0; lsb_rd_rename = '0; lsb_result = '0;
    modelReset();
    #12;
    checkOutput();
    rst = 0;

    // ADDI with ready operand: dispatched one cycle after issue.
    setIssue(6'h13, 4'd2, 32'd3, 0, 4'd0, 32'd5, 0, 4'd0, 32'd0);
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkValue("addi_enable", 64'(alu_enable), 64'd1);
    checkValue("addi_rs1", 64'(out_rs1_value), 64'd5);
    checkValue("addi_imm", 64'(out_imm), 64'd3);
    checkValue("addi_rd", 64'(out_rd_rename), 64'd2);

    // ADD waiting on tag 4, woken by an ALU broadcast.
    setIssue(6'h33, 4'd7, 32'd0, 1, 4'd4, 32'd0, 0, 4'd0, 32'd1);
    applyStimulus();
    idleInputs();
    applyStimulus();
    alu_broadcast = 1; alu_rd_rename = 4'd4; alu_result = 32'h10;
    applyStimulus();
    checkValue("wake_not_early", 64'(alu_enable), 64'd0);
    idleInputs();
    applyStimulus();
    checkValue("wake_enable", 64'(alu_enable), 64'd1);
    checkValue("wake_rs1", 64'(out_rs1_value), 64'h10);

    // Fill all eight entries, overflow, then free entry 0 and reuse it.
    for (int i = 0; i < 8; i++) begin
      setIssue(6'(i), 4'(i + 1), 32'(i), 1, 4'(i + 1), 32'd0, 0, 4'd0, 32'd0);
      applyStimulus();
    end
    checkValue("full_set", 64'(rs_full), 64'd1);
    setIssue(6'h3f, 4'd9, 32'd99, 0, 4'd0, 32'd1, 0, 4'd0, 32'd2);
    applyStimulus();
    checkValue("overflow_no_dispatch", 64'(alu_enable), 64'd0);
    idleInputs();
    alu_broadcast = 1; alu_rd_rename = 4'd1; alu_result = 32'hCAFE;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkValue("full_dispatch_rd", 64'(out_rd_rename), 64'd1);
    checkValue("full_drop", 64'(rs_full), 64'd0);
    setIssue(6'h01, 4'hE, 32'd0, 0, 4'd0, 32'd7, 0, 4'd0, 32'd8);
    alu_broadcast = 1; alu_rd_rename = 4'd2; alu_result = 32'hBEEF;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkValue("reuse_entry0_first", 64'(out_rd_rename), 64'hE);
    applyStimulus();
    rollback = 1;
    applyStimulus();
    idleInputs();

    // Issue-time bypass from the load-store bus.
    setIssue(6'h03, 4'd5, 32'd0, 1, 4'd6, 32'd0, 0, 4'd0, 32'd0);
    lsb_broadcast = 1; lsb_rd_rename = 4'd6; lsb_result = 32'hAB;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkValue("bypass_enable", 64'(alu_enable), 64'd1);
    checkValue("bypass_rs1", 64'(out_rs1_value), 64'hAB);

    // Rollback flushes three waiting entries.
    for (int i = 0; i < 3; i++) begin
      setIssue(6'h10, 4'(i), 32'd0, 1, 4'(10 + i), 32'd0, 0, 4'd0, 32'd0);
      applyStimulus();
    end
    idleInputs();
    rollback = 1;
    applyStimulus();
    checkValue("rollback_enable", 64'(alu_enable), 64'd0);
    checkValue("rollback_full", 64'(rs_full), 64'd0);
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      alu_broadcast = 1; alu_rd_rename = 4'(10 + i); alu_result = 32'h55;
      applyStimulus();
      checkValue("flushed_stay_gone", 64'(alu_enable), 64'd0);
    end
    idleInputs();

    // Asynchronous reset in the middle of a cycle while alu_enable is high.
    setIssue(6'h22, 4'd9, 32'd4, 0, 4'd0, 32'd3, 0, 4'd0, 32'd4);
    applyStimulus();
    idleInputs();
    applyStimulus();
    #2 rst = 1;
    #1;
    modelReset();
    checkValue("async_rst_enable", 64'(alu_enable), 64'd0);
    checkOutput();
    @(negedge clk) rst = 0;
    setIssue(6'h05, 4'd3, 32'd1, 0, 4'd0, 32'd1, 0, 4'd0, 32'd1);
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkValue("post_reset_rd", 64'(out_rd_rename), 64'd3);

    // Random traffic, including stalls, rollbacks and bus collisions.
    for (int n = 0; n < 600; n++) begin
      randomInputs();
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
